fft_result_unloader: RTL and testbench
======================================

Name: fft_result_unloader

Overview:
- Downstream consumer of the FFT core's result port.
- On a rising edge of fft_done it walks all N result bins through the core's read port (mem_address -> mem_data).
- Optionally applies bit-reversal so bins leave in natural frequency order.
- Streams {re, im} words out over a valid/ready handshake, absorbing downstream backpressure with a credit-controlled skid FIFO.

Parameters:
- N, 32, number of FFT points; power of two.
- ADDR_W, 5, log2(N); width of mem_address and out_index.
- DATA_W, 64, result word width: [63:32] real, [31:0] imaginary, passed through unmodified.
- RD_LAT, 1, cycles from mem_address change to valid mem_data.
- BITREV, 1, 1: mem_address = bit-reverse(k); 0: mem_address = k.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- fft_done  input  1  level from the FFT core, high while results are valid in memory
- mem_address  output  ADDR_W  read address into the FFT result memory
- mem_data  input  DATA_W  read data, valid RD_LAT cycles after mem_address
- out_valid  output  1  out_data/out_index/out_last valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_data  output  DATA_W  result bin word
- out_index  output  ADDR_W  natural-order bin index k of out_data
- out_last  output  1  high with bin k = N-1
- busy  output  1  high from frame start until the last bin is accepted
- frame_done  output  1  one-cycle pulse after the last bin is accepted
- abort  output  1  one-cycle pulse when fft_done falls mid-frame

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; counters, FIFO pointers and in-flight tracking cleared.
  - mem_address = 0, out_valid = 0, out_last = 0, busy = 0, frame_done = 0, abort = 0.
  - out_data = 0, out_index = 0.
  - Registered fft_done_q = 0.
- Start: the frame starts in IDLE when fft_done & ~fft_done_q. An fft_done already high at reset release does not start a frame until it has gone low and high again.
- States:
  - IDLE -> READ on start; k = 0; busy = 1.
  - READ: a read issues on cycle c when (fifo_count + inflight) < DEPTH.
    - DEPTH = RD_LAT + 2.
    - A read drives mem_address = map(k) and increments k.
    - After the issue with k = N-1: -> DRAIN.
  - DRAIN: no further reads. -> IDLE when the FIFO is empty and inflight = 0, with the final handshake done.
    - frame_done pulses in the cycle after the out_last handshake.
    - busy falls in that same cycle.
- Read pipeline:
  - A shift register of RD_LAT stages tracks {valid, k} per issued read.
  - When a stage exits, mem_data is written into the FIFO with k.
  - mem_address holds its last value when no read issues.
- FIFO:
  - Depth DEPTH, first-word-fall-through.
  - out_valid = ~empty; out_index = stored k; out_last = (stored k == N-1).
  - Push and pop in the same cycle: count unchanged.
  - Credit check guarantees the FIFO never overflows. An overflow is a design error and the bench asserts on it.
- Handshake:
  - out_data, out_index and out_last hold stable while out_valid & ~out_ready.
  - out_valid never drops without a handshake, except on abort or reset.
- Throughput: with out_ready held high, one bin per cycle.
  - First out_valid is RD_LAT+1 cycles after the start edge.
  - The last handshake is at cycle RD_LAT+N.
- Bit reversal: map(k) = k with bits [ADDR_W-1:0] reversed when BITREV = 1, otherwise k. out_index is always k.
- Abort:
  - Trigger: fft_done low while in READ or DRAIN.
  - FIFO and pipeline are flushed; out_valid = 0 next cycle; abort pulses once; -> IDLE; busy = 0.
  - No frame_done.
- A new rising edge of fft_done while busy and not aborting is ignored.
- Reset mid-frame: immediate return to reset values; no pulses.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N = 32, FFT_ADDR_W = 5, FFT_DATA_W = 64.
  - Unloader state enum {IDLE, READ, DRAIN}.
  - A bit_reverse function of width FFT_ADDR_W.
- One sub-module, fft_unload_fifo, parameterised on width and depth:
  - FWFT FIFO with count output.
  - Async active-high reset.

Test Plan:
- Natural flow (BITREV = 1, RD_LAT = 1, out_ready = 1, memory model mem[a] = {a, ~a}):
  - Raise fft_done.
  - mem_address sequence is 0,16,8,24,4,…,31.
  - out_index is 0..31 in order, with out_data[63:32] = bitrev(out_index).
  - out_last only at index 31; frame_done at cycle 34 after the edge.
- Backpressure: out_ready random at 30%.
  - All 32 bins are delivered exactly once, in order.
  - Stalled outputs stay stable.
  - FIFO count never exceeds 3.
- BITREV = 0, RD_LAT = 2: mem_address = 0..31 linear; first out_valid 3 cycles after start; no lost bins.
- Abort: drop fft_done after 10 bins are accepted.
  - abort pulses once; out_valid = 0 next cycle; no frame_done.
  - A fresh fft_done rising edge then delivers a full 32-bin frame.
- Level start: hold fft_done high across reset release; no frame until fft_done goes 0 then 1.
- Reset mid-DRAIN: assert rst asynchronously; out_valid, busy and mem_address = 0 immediately; no pulses.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: FFT result geometry, unloader state encoding and a bin-order helper.
package fft_pkg;
    localparam int FFT_N      = 32;
    localparam int FFT_ADDR_W = 5;
    localparam int FFT_DATA_W = 64;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} unload_state_t;

    function automatic logic [FFT_ADDR_W-1:0] bit_reverse(input logic [FFT_ADDR_W-1:0] a);
        logic [FFT_ADDR_W-1:0] r;
        for (int i = 0; i < FFT_ADDR_W; i++) r[i] = a[FFT_ADDR_W-1-i];
        return r;
    endfunction
endpackage

// File: rtl/fft_unload_fifo.sv
// fft_unload_fifo: first-word-fall-through FIFO with occupancy count and synchronous flush.
module fft_unload_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty    = count == '0;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fft_result_unloader.sv
// fft_result_unloader: on a rising fft_done walks the FFT result memory and streams
// {re, im} bins in natural order over valid/ready through a credit-sized skid FIFO.
module fft_result_unloader
    import fft_pkg::*;
#(
    parameter int N      = FFT_N,
    parameter int ADDR_W = FFT_ADDR_W,
    parameter int DATA_W = FFT_DATA_W,
    parameter int RD_LAT = 1,
    parameter int BITREV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_done,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              abort
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);

    unload_state_t            state, state_nxt;
    logic                     fft_done_q, armed, start, abort_c, rd_en, pop, last_pop, fifo_empty;
    logic [ADDR_W-1:0]        k, map_k, addr_q;
    logic [RD_LAT-1:0]        pipe_v;
    logic [ADDR_W-1:0]        pipe_k [RD_LAT];
    logic [CW-1:0]            fifo_count;
    logic [DATA_W+ADDR_W-1:0] fifo_q;

    always_comb begin
        map_k = k;
        if (BITREV != 0)
            for (int i = 0; i < ADDR_W; i++) map_k[i] = k[ADDR_W-1-i];
    end

    // A read only issues when every outstanding bin is guaranteed a FIFO slot.
    always_comb begin
        start     = state == IDLE && fft_done && !fft_done_q && armed;
        abort_c   = state != IDLE && !fft_done;
        rd_en     = state == READ && fft_done && int'(fifo_count) + $countones(pipe_v) < DEPTH;
        pop       = out_valid && out_ready;
        last_pop  = pop && out_last;
        state_nxt = state;
        if (abort_c)
            state_nxt = IDLE;
        else if (start)
            state_nxt = READ;
        else if (rd_en && k == ADDR_W'(N - 1))
            state_nxt = DRAIN;
        else if (state == DRAIN && last_pop)
            state_nxt = IDLE;
    end

    // armed blocks a frame from an fft_done level that was already high out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fft_done_q <= 1'b0;
            armed      <= 1'b0;
            k          <= '0;
            addr_q     <= '0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= state_nxt;
            fft_done_q <= fft_done;
            armed      <= armed || !fft_done;
            k          <= start ? '0 : rd_en ? k + 1'b1 : k;
            addr_q     <= rd_en ? map_k : addr_q;
            frame_done <= !abort_c && state == DRAIN && last_pop;
            abort      <= abort_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_k[i] <= '0;
        end else begin
            pipe_v    <= abort_c ? '0 : RD_LAT'({pipe_v, rd_en});
            pipe_k[0] <= k;
            for (int i = 1; i < RD_LAT; i++) pipe_k[i] <= pipe_k[i-1];
        end
    end

    fft_unload_fifo #(.W(DATA_W + ADDR_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_c),
        .push      (pipe_v[RD_LAT-1]),
        .push_data ({mem_data, pipe_k[RD_LAT-1]}),
        .pop       (pop),
        .pop_data  (fifo_q),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_address = rd_en ? map_k : addr_q;
    assign out_valid   = !fifo_empty;
    assign out_data    = fifo_q[DATA_W+ADDR_W-1:ADDR_W];
    assign out_index   = fifo_q[ADDR_W-1:0];
    assign out_last    = out_valid && out_index == ADDR_W'(N - 1);
    assign busy        = state != IDLE;
endmodule

// File: tb/tb_fft_result_unloader.sv
// tb_fft_result_unloader: directed checks of a bit-reversed RD_LAT=1 unloader and a
// linear RD_LAT=2 unloader against a memory holding {a, ~a} at address a.
`timescale 1ns/1ps
module tb_fft_result_unloader;
    logic        clk = 1'b0, rst = 1'b1;
    logic        fft_done = 1'b0, fft_done2 = 1'b0, out_ready = 1'b1, out_ready2 = 1'b1;
    logic [4:0]  mem_address, mem_address2, out_index, out_index2;
    logic [63:0] mem_data, mem_data2, mem_pipe2, out_data, out_data2;
    logic        out_valid, out_valid2, out_last, out_last2, busy, busy2;
    logic        frame_done, frame_done2, abort, abort2;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] rev5(input int v);
        logic [4:0] a, r;
        a = 5'(v);
        for (int i = 0; i < 5; i++) r[i] = a[4-i];
        return r;
    endfunction

    function automatic logic [63:0] word(input logic [4:0] a);
        return {27'd0, a, ~{27'd0, a}};
    endfunction

    always @(posedge clk) begin
        mem_data  <= word(mem_address);
        mem_pipe2 <= word(mem_address2);
        mem_data2 <= mem_pipe2;
    end

    fft_result_unloader dut (
        .clk(clk), .rst(rst), .fft_done(fft_done), .mem_address(mem_address), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .busy(busy), .frame_done(frame_done), .abort(abort)
    );

    fft_result_unloader #(.RD_LAT(2), .BITREV(0)) dut2 (
        .clk(clk), .rst(rst), .fft_done(fft_done2), .mem_address(mem_address2), .mem_data(mem_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_index(out_index2),
        .out_last(out_last2), .busy(busy2), .frame_done(frame_done2), .abort(abort2)
    );

    task automatic test_reset();
        rst = 1'b1;
        fft_done = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (mem_address !== 5'd0) begin errors++; $display("FAIL reset_mem_address got=%0d want=0", mem_address); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (out_index !== 5'd0) begin errors++; $display("FAIL reset_out_index got=%0d want=0", out_index); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b want=0", abort); end
    endtask

    task automatic test_level_start();
        int seen = 0;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (busy || out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL level_start_early active_cycles=%0d want=0", seen); end
        fft_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_natural();
        int first = -1, hs = 0, fd = 0, fd_cycle = -1;
        out_ready = 1'b1;
        fft_done = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 32) begin
                checks++;
                if (mem_address !== rev5(c)) begin errors++; $display("FAIL natural_addr cycle=%0d got=%0d want=%0d", c, mem_address, rev5(c)); end
            end
            if (out_valid && first < 0) first = c;
            if (out_valid) begin
                checks++;
                if (out_index !== 5'(hs) || out_data !== word(rev5(hs)) || out_last !== (hs == 31)) begin
                    errors++;
                    $display("FAIL natural_bin got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                             out_index, out_data, out_last, hs, word(rev5(hs)), hs == 31);
                end
                hs++;
            end
            if (frame_done) begin fd++; fd_cycle = c; end
            if (c == 33) begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL natural_busy_last got=%b want=1", busy); end end
            if (c == 34) begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL natural_busy_end got=%b want=0", busy); end end
        end
        checks++; if (first !== 2) begin errors++; $display("FAIL natural_first_valid got=%0d want=2", first); end
        checks++; if (hs !== 32) begin errors++; $display("FAIL natural_bin_count got=%0d want=32", hs); end
        checks++; if (fd !== 1 || fd_cycle !== 34) begin errors++; $display("FAIL natural_frame_done pulses=%0d cycle=%0d want 1 at 34", fd, fd_cycle); end
    endtask

    task automatic test_backpressure();
        int hs = 0, fd = 0, unstable = 0, over = 0;
        logic stall = 1'b0, pl = 1'b0;
        logic [63:0] pd = '0;
        logic [4:0] pi = '0;
        fft_done = 1'b0;
        @(negedge clk);
        fft_done = 1'b1;
        for (int c = 0; c < 2000 && fd == 0; c++) begin
            @(negedge clk);
            if (stall && (out_valid !== 1'b1 || out_data !== pd || out_index !== pi || out_last !== pl)) unstable++;
            if (frame_done) fd++;
            out_ready = ($urandom_range(0, 99) < 30);
            if (dut.u_fifo.push && dut.fifo_count == 2'd3 && !(out_valid && out_ready)) over++;
            if (out_valid && out_ready) begin
                checks++;
                if (out_index !== 5'(hs) || out_data !== word(rev5(hs)) || out_last !== (hs == 31)) begin
                    errors++;
                    $display("FAIL bp_bin got idx=%0d data=%h want idx=%0d data=%h", out_index, out_data, hs, word(rev5(hs)));
                end
                hs++;
            end
            stall = out_valid && !out_ready;
            pd = out_data;
            pi = out_index;
            pl = out_last;
        end
        out_ready = 1'b1;
        checks++; if (hs !== 32) begin errors++; $display("FAIL bp_bin_count got=%0d want=32", hs); end
        checks++; if (fd !== 1) begin errors++; $display("FAIL bp_frame_done got=%0d want=1", fd); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stall_stable changes=%0d want=0", unstable); end
        checks++; if (over !== 0) begin errors++; $display("FAIL bp_fifo_overflow events=%0d want=0", over); end
    endtask

    task automatic test_bitrev0();
        int first = -1, hs = 0, fd = 0, fd_cycle = -1;
        out_ready2 = 1'b1;
        fft_done2 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 32) begin
                checks++;
                if (mem_address2 !== 5'(c)) begin errors++; $display("FAIL lin_addr cycle=%0d got=%0d want=%0d", c, mem_address2, c); end
            end
            if (out_valid2 && first < 0) first = c;
            if (out_valid2) begin
                checks++;
                if (out_index2 !== 5'(hs) || out_data2 !== word(5'(hs)) || out_last2 !== (hs == 31)) begin
                    errors++;
                    $display("FAIL lin_bin got idx=%0d data=%h want idx=%0d data=%h", out_index2, out_data2, hs, word(5'(hs)));
                end
                hs++;
            end
            if (frame_done2) begin fd++; fd_cycle = c; end
        end
        fft_done2 = 1'b0;
        checks++; if (first !== 3) begin errors++; $display("FAIL lin_first_valid got=%0d want=3", first); end
        checks++; if (hs !== 32) begin errors++; $display("FAIL lin_bin_count got=%0d want=32", hs); end
        checks++; if (fd !== 1 || fd_cycle !== 35) begin errors++; $display("FAIL lin_frame_done pulses=%0d cycle=%0d want 1 at 35", fd, fd_cycle); end
    endtask

    task automatic test_abort();
        int hs = 0, ab = 0, fd = 0;
        fft_done = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        fft_done = 1'b1;
        for (int c = 0; c < 100 && hs < 10; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got=%b want=1", out_valid); end
        fft_done = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got=%b want=1", abort); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        repeat (6) begin
            if (abort) ab++;
            if (frame_done) fd++;
            @(negedge clk);
        end
        checks++; if (ab !== 1 || fd !== 0) begin errors++; $display("FAIL abort_pulses abort=%0d frame_done=%0d want 1 and 0", ab, fd); end
        hs = 0;
        fd = 0;
        out_ready = 1'b1;
        fft_done = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (out_index !== 5'(hs) || out_data !== word(rev5(hs))) begin
                    errors++;
                    $display("FAIL restart_bin got idx=%0d data=%h want idx=%0d data=%h", out_index, out_data, hs, word(rev5(hs)));
                end
                hs++;
            end
            if (frame_done) fd++;
        end
        checks++; if (hs !== 32 || fd !== 1) begin errors++; $display("FAIL restart_frame bins=%0d frame_done=%0d want 32 and 1", hs, fd); end
    endtask

    task automatic test_reset_mid_drain();
        int pulses = 0;
        fft_done = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        fft_done = 1'b1;
        repeat (33) @(negedge clk);
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL drain_pre busy=%b valid=%b want 1 1", busy, out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b want=0", busy); end
        checks++; if (mem_address !== 5'd0) begin errors++; $display("FAIL arst_mem_address got=%0d want=0", mem_address); end
        repeat (3) begin
            @(negedge clk);
            if (frame_done || abort || busy) pulses++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (frame_done || abort || busy) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL arst_pulses got=%0d want=0", pulses); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_level_start();
        test_natural();
        test_backpressure();
        test_bitrev0();
        test_abort();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
